// File: rtl/cmd_encoder.sv
// Manchester-II uplink transmitter: sync, 16 data bits MSB first, optional parity, forced idle gap.
// Define CMD_ENCODER_PARITY_EN to append an odd-parity bit after the data bits.
module cmd_encoder #(
  parameter int HALF_BIT_CLKS = 24,
  parameter int GAP_HALF_BITS = 4
) (
  input  logic        clock_system,
  input  logic        reset,
  input  logic [15:0] tx_datareg,
  input  logic        tx_is_cmd,
  input  logic        tx_start,
  output logic        tx_busy,
  output logic        tx_done,
  output logic        udi2md,
  output logic        udi2md_en
);

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
`ifdef CMD_ENCODER_PARITY_EN
    PARITY,
`endif
    GAP
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  hb_cnt, hb_cnt_nxt;
  logic [5:0]  half_idx, half_idx_nxt;
  logic [15:0] shift_q, shift_nxt;
  logic        is_cmd_q, is_cmd_nxt;
  logic        line_nxt, en_nxt, done_nxt;
  logic        hb_term;
`ifdef CMD_ENCODER_PARITY_EN
  logic        par_q, par_nxt;
`endif

  assign hb_term = (hb_cnt == 8'(HALF_BIT_CLKS - 1));

  always_comb begin
    state_nxt    = state;
    hb_cnt_nxt   = hb_term ? 8'd0 : hb_cnt + 8'd1;
    half_idx_nxt = hb_term ? half_idx + 6'd1 : half_idx;
    shift_nxt    = shift_q;
    is_cmd_nxt   = is_cmd_q;
    done_nxt     = 1'b0;
`ifdef CMD_ENCODER_PARITY_EN
    par_nxt      = par_q;
`endif
    case (state)
      IDLE: begin
        hb_cnt_nxt   = 8'd0;
        half_idx_nxt = 6'd0;
        if (tx_start) begin
          state_nxt  = SYNC;
          shift_nxt  = tx_datareg;
          is_cmd_nxt = tx_is_cmd;
`ifdef CMD_ENCODER_PARITY_EN
          par_nxt    = ~^tx_datareg;
`endif
        end
      end
      SYNC: if (hb_term && half_idx == 6'd5) begin
        state_nxt    = DATA;
        half_idx_nxt = 6'd0;
      end
      DATA: begin
        if (hb_term && half_idx[0]) shift_nxt = {shift_q[14:0], 1'b0};
        if (hb_term && half_idx == 6'd31) begin
`ifdef CMD_ENCODER_PARITY_EN
          state_nxt    = PARITY;
`else
          state_nxt    = GAP;
`endif
          half_idx_nxt = 6'd0;
        end
      end
`ifdef CMD_ENCODER_PARITY_EN
      PARITY: if (hb_term && half_idx == 6'd1) begin
        state_nxt    = GAP;
        half_idx_nxt = 6'd0;
      end
`endif
      GAP: if (hb_term && half_idx == 6'(GAP_HALF_BITS - 1)) begin
        state_nxt    = IDLE;
        half_idx_nxt = 6'd0;
        done_nxt     = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase

    // Line level is derived from the next-cycle state so the registered output
    // lines up with the state it belongs to (first sync half-bit right after acceptance).
    line_nxt = 1'b0;
    en_nxt   = 1'b0;
    case (state_nxt)
      SYNC: begin
        en_nxt   = 1'b1;
        line_nxt = is_cmd_nxt ? (half_idx_nxt < 6'd3) : (half_idx_nxt < 6'd5);
      end
      DATA: begin
        en_nxt   = 1'b1;
        line_nxt = shift_nxt[15] ^ half_idx_nxt[0];
      end
`ifdef CMD_ENCODER_PARITY_EN
      PARITY: begin
        en_nxt   = 1'b1;
        line_nxt = par_nxt ^ half_idx_nxt[0];
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clock_system) begin
    if (reset) begin
      state     <= IDLE;
      hb_cnt    <= '0;
      half_idx  <= '0;
      shift_q   <= '0;
      is_cmd_q  <= 1'b0;
      udi2md    <= 1'b0;
      udi2md_en <= 1'b0;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
`ifdef CMD_ENCODER_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      hb_cnt    <= hb_cnt_nxt;
      half_idx  <= half_idx_nxt;
      shift_q   <= shift_nxt;
      is_cmd_q  <= is_cmd_nxt;
      udi2md    <= line_nxt;
      udi2md_en <= en_nxt;
      tx_busy   <= (state_nxt != IDLE);
      tx_done   <= done_nxt;
`ifdef CMD_ENCODER_PARITY_EN
      par_q     <= par_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_cmd_encoder.sv
// Bench for cmd_encoder: default-timing instance plus a fast (2-cycle half-bit, 1 half-bit gap) instance,
// both checked cycle by cycle against a half-bit list built from the framing rules.
module tb_cmd_encoder;
  logic clock_system = 1'b0;
  always #5 clock_system = ~clock_system;

  logic        reset_a, reset_b, start_a, start_b, is_cmd;
  logic [15:0] datareg;
  logic        busy_a, done_a, udi_a, en_a;
  logic        busy_b, done_b, udi_b, en_b;

  cmd_encoder dut_a (
    .clock_system(clock_system), .reset(reset_a), .tx_datareg(datareg), .tx_is_cmd(is_cmd),
    .tx_start(start_a), .tx_busy(busy_a), .tx_done(done_a), .udi2md(udi_a), .udi2md_en(en_a));

  cmd_encoder #(.HALF_BIT_CLKS(2), .GAP_HALF_BITS(1)) dut_b (
    .clock_system(clock_system), .reset(reset_b), .tx_datareg(datareg), .tx_is_cmd(is_cmd),
    .tx_start(start_b), .tx_busy(busy_b), .tx_done(done_b), .udi2md(udi_b), .udi2md_en(en_b));

  int tests = 0;
  int fails = 0;
  bit sel = 1'b0;
  logic line, en, busy, done;
  assign line = sel ? udi_b  : udi_a;
  assign en   = sel ? en_b   : en_a;
  assign busy = sel ? busy_b : busy_a;
  assign done = sel ? done_b : done_a;

  task automatic set_start(input logic v);
    if (sel) start_b = v; else start_a = v;
  endtask

  task automatic set_reset(input logic v);
    if (sel) reset_b = v; else reset_a = v;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // mode 0: single frame; 1: tx_start held high, next word queued; 2: tx_start pulsed in the done cycle
  task automatic frame(input logic [15:0] w, input bit cmd, input bit already, input int mode,
                       input logic [15:0] nw, input bit ncmd, input int poke_k, input string tag);
    int hbc = sel ? 2 : 24;
    int gap = sel ? 1 : 4;
    bit q[$];
    int nh, len, wait_n;
    int ml = 0, me = 0, mb = 0, md = 0, en_cnt = 0;
    logic [15:0] dec = '0;
    logic s3 = 1'bx;
    q = {};
    if (cmd) q = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    else     q = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 15; i >= 0; i--) begin
      q.push_back(w[i]);
      q.push_back(!w[i]);
    end
`ifdef CMD_ENCODER_PARITY_EN
    q.push_back(($countones(w) % 2) == 0);
    q.push_back(($countones(w) % 2) != 0);
`endif
    nh  = q.size();
    len = (nh + gap) * hbc;
    if (!already) begin
      wait_n = 0;
      while (busy !== 1'b0 && wait_n < 3000) begin
        @(negedge clock_system);
        wait_n++;
      end
      chk({tag, " idle_before_start"}, busy, 0);
      datareg = w;
      is_cmd  = cmd;
      set_start(1'b1);
    end
    @(negedge clock_system);
    if (mode == 1) begin
      datareg = nw;
      is_cmd  = ncmd;
    end else begin
      set_start(1'b0);
      datareg = 16'($urandom);
      is_cmd  = 1'($urandom);
    end
    for (int k = 1; k <= len; k++) begin
      int h = (k - 1) / hbc;
      bit el = (h < nh) ? q[h] : 1'b0;
      bit ee = (h < nh);
      if (line !== el) ml++;
      if (en !== ee) me++;
      if (busy !== 1'b1) mb++;
      if (done !== 1'b0) md++;
      if (en === 1'b1) en_cnt++;
      if ((k - 1) % hbc == hbc / 2) begin
        if (h == 3) s3 = line;
        if (h >= 6 && h < 38 && h % 2 == 0) dec = {dec[14:0], line};
      end
      if (k == poke_k) begin
        datareg = 16'h1234;
        is_cmd  = !cmd;
        set_start(1'b1);
      end
      if (k == poke_k + 1) set_start(1'b0);
      @(negedge clock_system);
    end
    chk({tag, " line_mismatch_cycles"}, ml, 0);
    chk({tag, " en_mismatch_cycles"}, me, 0);
    chk({tag, " busy_low_cycles"}, mb, 0);
    chk({tag, " early_done_cycles"}, md, 0);
    chk({tag, " en_high_cycles"}, en_cnt, nh * hbc);
    chk({tag, " decoded_word"}, dec, w);
    chk({tag, " decoded_cmd_sync"}, !s3, cmd);
    chk({tag, " end_busy_done_en_line"}, {busy, done, en, line}, 4'b0100);
    if (mode == 2) begin
      datareg = nw;
      is_cmd  = ncmd;
      set_start(1'b1);
    end
    if (mode == 0) begin
      @(negedge clock_system);
      chk({tag, " done_one_cycle"}, {busy, done}, 2'b00);
    end
  endtask

  initial begin
    reset_a = 1'b1; reset_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
    datareg = '0; is_cmd = 1'b0;
    repeat (3) @(negedge clock_system);
    chk("in_reset", {udi_a, en_a, busy_a, done_a, udi_b, en_b, busy_b, done_b}, 0);
    reset_a = 1'b0; reset_b = 1'b0;
    @(negedge clock_system);
    chk("after_reset", {udi_a, en_a, busy_a, done_a, udi_b, en_b, busy_b, done_b}, 0);

    sel = 1'b0;
    frame(16'h9930, 1'b1, 1'b0, 0, 16'h0, 1'b0, -1, "cmd_9930");
    frame(16'hA5A5, 1'b0, 1'b0, 0, 16'h0, 1'b0, -1, "data_A5A5");
    frame(16'hFFFF, 1'b1, 1'b0, 2, 16'h0001, 1'b0, 100, "ffff_ignore_start");
    frame(16'h0001, 1'b0, 1'b1, 0, 16'h0, 1'b0, -1, "0001_done_cycle_start");

    datareg = 16'hC3A5; is_cmd = 1'b0; set_start(1'b1);
    @(negedge clock_system);
    set_start(1'b0);
    repeat (20 * 24) @(negedge clock_system);
    set_reset(1'b1);
    @(negedge clock_system);
    set_reset(1'b0);
    chk("mid_frame_reset", {udi_a, en_a, busy_a, done_a}, 0);
    repeat (5) @(negedge clock_system);
    chk("post_reset_quiet", {udi_a, en_a, busy_a, done_a}, 0);
    frame(16'h5A3C, 1'b1, 1'b0, 0, 16'h0, 1'b0, -1, "after_reset");

    repeat (3) frame(16'($urandom), 1'($urandom), 1'b0, 0, 16'h0, 1'b0, -1, "rand_default");

    sel = 1'b1;
    frame(16'h0000, 1'b1, 1'b0, 1, 16'hFFFF, 1'b0, -1, "fast_0000_held");
    frame(16'hFFFF, 1'b0, 1'b1, 0, 16'h0, 1'b0, -1, "fast_FFFF_b2b");
    repeat (8) frame(16'($urandom), 1'($urandom), 1'b0, 0, 16'h0, 1'b0, -1, "rand_fast");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
